ntt_basemul: RTL and testbench

NTT_BASEMUL -- requirements
Module: ntt_basemul

---
 rtl/ntt_basemul.sv | 79 +++++++
 tb/tb_ntt_basemul.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ntt_basemul.sv
// ntt_basemul: Kyber NTT-domain pairwise base multiply, q=3329, fixed 3-cycle latency.
module ntt_basemul (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        in_valid,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic [6:0]  zeta_addr,
  input  logic [15:0] zeta,
  output logic [15:0] c0,
  output logic [15:0] c1,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);
  localparam int unsigned Q = 3329;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t      state_q;
  logic [6:0]  cnt_q;
  logic        v1_q, v2_q, v3_q, out_valid_q;
  logic [23:0] p00_q, p11_q;
  logic [24:0] s_q, sum_q;
  logic [15:0] g_q, g2_q, g_d, c0_q, c1_q;
  logic [11:0] m00_q, m11_q, c1m_q, c1s_q;
  logic        acc;
  assign acc       = state_q == RUN && in_valid;
  assign zeta_addr = {1'b1, cnt_q[6:1]};
  // Odd pairs use the negated twiddle; zero stays zero so g is fully reduced.
  assign g_d       = cnt_q[0] && zeta != 16'd0 ? 16'(Q) - zeta : zeta;
  assign c0        = c0_q;
  assign c1        = c1_q;
  assign out_valid = out_valid_q;
  assign busy      = state_q == RUN || state_q == FLUSH;
  assign done      = state_q == DONE;
  always_ff @(posedge clk) begin
    p00_q <= 24'(a0) * 24'(b0);
    p11_q <= 24'(a1) * 24'(b1);
    s_q   <= 25'(a0) * 25'(b1) + 25'(a1) * 25'(b0);
    g_q   <= g_d;
    m00_q <= 12'(p00_q % 24'(Q));
    m11_q <= 12'(p11_q % 24'(Q));
    c1m_q <= 12'(s_q % 25'(Q));
    g2_q  <= g_q;
    sum_q <= 25'(m00_q) + 25'(m11_q) * 25'(g2_q);
    c1s_q <= c1m_q;
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 7'd0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      c0_q        <= 16'd0;
      c1_q        <= 16'd0;
    end else begin
      v1_q        <= acc;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      if (v3_q) begin
        c0_q <= 16'(sum_q % 25'(Q));
        c1_q <= {4'd0, c1s_q};
      end
      if (state_q == IDLE && set) begin
        state_q <= RUN;
        cnt_q   <= 7'd0;
      end
      if (acc) begin
        cnt_q <= cnt_q + 7'd1;
        if (cnt_q == 7'd127) state_q <= FLUSH;
      end
      if (state_q == FLUSH && !(v1_q || v2_q || v3_q)) state_q <= DONE;
      if (state_q == DONE) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ntt_basemul.sv
// tb_ntt_basemul: directed and full-pass checks of ntt_basemul against a software basemul model.
module tb_ntt_basemul;
  logic        clk = 1'b0, reset = 1'b1, set = 1'b0, in_valid = 1'b0;
  logic [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, zeta, c0, c1;
  logic [6:0]  zeta_addr;
  logic        out_valid, busy, done;
  logic [31:0] oq[$], eq[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_out_cyc = 0, passed = 0, total = 0, acc = 0, d0 = 0;

  ntt_basemul dut (
    .clk(clk), .reset(reset), .set(set), .in_valid(in_valid),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .zeta_addr(zeta_addr), .zeta(zeta),
    .c0(c0), .c1(c1), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Twiddle ROM stand-in: address 64 reads 17, 65 reads 118, and so on.
  function automatic logic [15:0] rom(input logic [6:0] a);
    return 16'((17 + (int'(a) - 64) * 101) % 3329);
  endfunction
  assign zeta = rom(zeta_addr);

  function automatic logic [31:0] bm(input longint x0, x1, y0, y1, input int i);
    longint z, g, r0, r1;
    z  = longint'(rom(7'(64 + i / 2)));
    g  = (i % 2 == 0) ? z : (3329 - z) % 3329;
    r0 = (x0 * y0 + x1 * y1 * g) % 3329;
    r1 = (x0 * y1 + x1 * y0) % 3329;
    return {16'(r0), 16'(r1)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      oq.push_back({c0, c1});
      last_out_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input logic [15:0] x0, x1, y0, y1);
    a0 = x0; a1 = x1; b0 = y0; b1 = y1; in_valid = 1'b1;
  endtask

  initial begin
    tick; tick;
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_c0", 32'(c0), 0);
    chk("rst_c1", 32'(c1), 0);
    chk("rst_zaddr", 32'(zeta_addr), 64);
    drive(16'd1, 16'd1, 16'd1, 16'd1);
    repeat (4) tick;
    in_valid = 1'b0;
    chk("idle_in_valid_ignored", oq.size(), 0);
    chk("idle_busy", 32'(busy), 0);
    // Pass A: identity, negated twiddle on odd pair, max operands on pair 2
    set = 1'b1; tick; set = 1'b0;
    chk("run_busy", 32'(busy), 1);
    chk("p0_zaddr", 32'(zeta_addr), 64);
    drive(16'd1, 16'd0, 16'd5, 16'd7); tick; in_valid = 1'b0;
    tick; chk("lat_n1", 32'(out_valid), 0);
    tick; chk("lat_n2", 32'(out_valid), 0);
    tick; chk("lat_n3", 32'(out_valid), 1);
    chk("ident_c0", 32'(c0), 5);
    chk("ident_c1", 32'(c1), 7);
    tick;
    chk("bubble_out_valid", 32'(out_valid), 0);
    chk("hold_c0", 32'(c0), 5);
    chk("hold_c1", 32'(c1), 7);
    chk("p1_zaddr", 32'(zeta_addr), 64);
    drive(16'd0, 16'd1, 16'd0, 16'd1); tick;
    chk("p2_zaddr", 32'(zeta_addr), 65);
    drive(16'd3328, 16'd3328, 16'd3328, 16'd3328); tick; in_valid = 1'b0;
    tick; tick;
    chk("neg_valid", 32'(out_valid), 1);
    chk("neg_c0", 32'(c0), 3312);
    chk("neg_c1", 32'(c1), 0);
    tick;
    chk("p2max_c0", 32'(c0), 119);
    chk("p2max_c1", 32'(c1), 2);
    // Reset beats set and in_valid in the same cycle
    reset = 1'b1; set = 1'b1; in_valid = 1'b1; tick;
    reset = 1'b0; set = 1'b0; in_valid = 1'b0;
    chk("prio_busy", 32'(busy), 0);
    chk("prio_out_valid", 32'(out_valid), 0);
    chk("prio_c0", 32'(c0), 0);
    // Pass B: positive twiddle on pair 0
    set = 1'b1; tick; set = 1'b0;
    drive(16'd0, 16'd1, 16'd0, 16'd1); tick; in_valid = 1'b0;
    tick; tick; tick;
    chk("pos_c0", 32'(c0), 17);
    chk("pos_c1", 32'(c1), 0);
    reset = 1'b1; tick; reset = 1'b0;
    // Pass C: max operands on pair 0
    set = 1'b1; tick; set = 1'b0;
    drive(16'd3328, 16'd3328, 16'd3328, 16'd3328); tick; in_valid = 1'b0;
    tick; tick; tick;
    chk("max_c0", 32'(c0), 18);
    chk("max_c1", 32'(c1), 2);
    reset = 1'b1; tick; reset = 1'b0;
    chk("pre_full_done_cnt", 32'(done_cnt), 0);
    // Pass D: full 128-pair pass with random gaps and a stray set mid-run
    oq.delete(); eq.delete();
    set = 1'b1; tick; set = 1'b0;
    acc = 0;
    for (int k = 0; k < 1000 && acc < 128; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      set = (acc == 40);
      if (in_valid) begin
        a0 = 16'($urandom_range(0, 3328)); a1 = 16'($urandom_range(0, 3328));
        b0 = 16'($urandom_range(0, 3328)); b1 = 16'($urandom_range(0, 3328));
        eq.push_back(bm(longint'(a0), longint'(a1), longint'(b0), longint'(b1), acc));
      end
      tick;
      if (in_valid) acc++;
    end
    in_valid = 1'b0; set = 1'b0;
    chk("full_accepted", 32'(acc), 128);
    for (int k = 0; k < 20 && done_cnt == 0; k++) tick;
    tick; tick;
    chk("full_out_count", oq.size(), 128);
    if (oq.size() == 128 && eq.size() == 128)
      for (int i = 0; i < 128; i++) chk($sformatf("full_out[%0d]", i), oq[i], eq[i]);
    chk("full_done_pulses", 32'(done_cnt), 1);
    chk("done_after_last_out", 32'(int'(last_out_cyc < done_cyc)), 1);
    chk("post_done_busy", 32'(busy), 0);
    chk("post_done_done", 32'(done), 0);
    // Pass E: abort at pair 60, then a fresh pass
    set = 1'b1; tick; set = 1'b0;
    for (int k = 0; k < 60; k++) begin
      drive(16'd1, 16'd2, 16'd3, 16'd4);
      tick;
    end
    reset = 1'b1; set = 1'b1; in_valid = 1'b1; tick;
    reset = 1'b0; set = 1'b0; in_valid = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    d0 = done_cnt;
    oq.delete();
    repeat (6) tick;
    chk("abort_no_out", oq.size(), 0);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    set = 1'b1; tick; set = 1'b0;
    chk("fresh_busy", 32'(busy), 1);
    chk("fresh_zaddr", 32'(zeta_addr), 64);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
